// File: rtl/stream_demux_n_if.sv
// Stream bundle for the 1-to-N demultiplexer: one input beat with lane select,
// N registered output lanes and the drop counter.
interface stream_demux_n_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic [CNT_W-1:0]   drop_count;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_count
    );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer: each lane has a one-entry holding
// register, out-of-range selects are accepted, discarded and counted.
module stream_demux_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    stream_demux_n_if.slave   bus
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]       r_full;
    logic [N*WIDTH-1:0] r_data;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [N-1:0]       w_can_take;
    logic [N-1:0]       w_load;
    logic               w_in_range;
    logic               w_sel_ok;
    logic               w_in_ready;
    logic               w_accept;

    // Range check only exists when N leaves unused select codes.
    if ((1 << SEL_W) == N) begin : g_pow2
        assign w_in_range = 1'b1;
    end else begin : g_npow2
        assign w_in_range = (bus.in_sel < SEL_W'(N));
    end

    always_comb begin
        w_can_take = '0;
        for (int i = 0; i < N; i++) begin
            w_can_take[i] = !r_full[i] || bus.out_ready[i];
        end
    end

    always_comb begin
        w_sel_ok = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                w_sel_ok = w_can_take[i];
            end
        end
    end

    always_comb begin
        w_in_ready = !rst && (w_in_range ? w_sel_ok : 1'b1);
        w_accept   = bus.in_valid && w_in_ready;
        w_load     = '0;
        for (int i = 0; i < N; i++) begin
            w_load[i] = w_accept && w_in_range && (bus.in_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                // A load wins over a drain, giving same-cycle pass-through reload.
                if (w_load[i]) begin
                    r_data[i*WIDTH +: WIDTH] <= bus.in_data;
                    r_full[i]                <= 1'b1;
                end else if (r_full[i] && bus.out_ready[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_accept && !w_in_range && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_full;
    assign bus.out_data   = r_data;
    assign bus.drop_count = r_drop_cnt;
endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: per-lane scoreboard on a N=4 instance plus a
// directed drop-counter check on a N=3, CNT_W=2 instance.
module tb_stream_demux_n;
    bit   clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stream_demux_n_if #(.N(4), .WIDTH(8), .CNT_W(8)) ifa ();
    stream_demux_n_if #(.N(3), .WIDTH(8), .CNT_W(2)) ifb ();

    stream_demux_n #(.N(4), .WIDTH(8), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    stream_demux_n #(.N(3), .WIDTH(8), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: queue per lane, pushed on accept, popped on drain.
    logic [7:0] q [4][$];
    logic [7:0] m_drop;

    always @(negedge clk) begin
        logic exp_ready;
        int   s;
        if (rst) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            m_drop = '0;
            chk("rst_valid", 64'(ifa.out_valid), 64'h0);
            chk("rst_data", 64'(ifa.out_data), 64'h0);
            chk("rst_drop", 64'(ifa.drop_count), 64'h0);
            chk("rst_in_ready", 64'(ifa.in_ready), 64'h0);
        end else begin
            s = int'(ifa.in_sel);
            exp_ready = (q[s].size() == 0) || (ifa.out_ready[s] === 1'b1);
            chk("in_ready", 64'(ifa.in_ready), 64'(exp_ready));
            chk("drop_count", 64'(ifa.drop_count), 64'(m_drop));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("valid%0d", i), 64'(ifa.out_valid[i]), 64'(q[i].size() != 0));
                if (q[i].size() != 0)
                    chk($sformatf("data%0d", i), 64'(ifa.out_data[i*8 +: 8]), 64'(q[i][0]));
            end
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() != 0 && ifa.out_ready[i] === 1'b1) void'(q[i].pop_front());
            end
            if (ifa.in_valid === 1'b1 && exp_ready) q[s].push_back(ifa.in_data);
        end
    end

    task automatic send_a(logic [7:0] d, logic [1:0] s);
        ifa.in_data  = d;
        ifa.in_sel   = s;
        ifa.in_valid = 1'b1;
    endtask

    logic [1:0] drop_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst           = 1'b1;
        ifa.in_data   = '0;
        ifa.in_sel    = '0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = '0;
        ifb.in_data   = '0;
        ifb.in_sel    = '0;
        ifb.in_valid  = 1'b0;
        ifb.out_ready = '0;
        repeat (2) cyc();
        chk("init_in_ready", 64'(ifa.in_ready), 64'h0);
        chk("init_valid", 64'(ifa.out_valid), 64'h0);
        rst = 1'b0;
        cyc();

        // Basic routing
        ifa.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            send_a(8'hA0 + 8'(k), 2'(k));
            #1;
            chk("route_ready", 64'(ifa.in_ready), 64'h1);
            cyc();
            chk("route_valid", 64'(ifa.out_valid), 64'(4'b0001 << k));
            chk("route_data", 64'(ifa.out_data[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
        end
        ifa.in_valid = 1'b0;
        cyc();
        chk("route_idle", 64'(ifa.out_valid), 64'h0);

        // Backpressure isolation
        ifa.out_ready = 4'b0000;
        send_a(8'h11, 2'd1);
        cyc();
        chk("bp_hold", 64'(ifa.out_valid), 64'b0010);
        send_a(8'h22, 2'd1);
        #1;
        chk("bp_blocked", 64'(ifa.in_ready), 64'h0);
        repeat (2) cyc();
        chk("bp_still", 64'(ifa.out_data[15:8]), 64'h11);
        send_a(8'h33, 2'd3);
        #1;
        chk("bp_other_lane", 64'(ifa.in_ready), 64'h1);
        cyc();
        chk("bp_lane3", 64'(ifa.out_valid), 64'b1010);
        send_a(8'h22, 2'd1);
        ifa.out_ready = 4'b0010;
        #1;
        chk("bp_reload_ready", 64'(ifa.in_ready), 64'h1);
        cyc();
        chk("bp_reload_data", 64'(ifa.out_data[15:8]), 64'h22);
        ifa.in_valid = 1'b0;
        cyc();
        chk("bp_drained", 64'(ifa.out_valid), 64'b1000);
        ifa.out_ready = 4'b1000;
        cyc();
        chk("bp_empty", 64'(ifa.out_valid), 64'h0);

        // Pass-through on lane 0
        ifa.out_ready = 4'b0000;
        send_a(8'hFF, 2'd0);
        cyc();
        ifa.out_ready = 4'b0001;
        for (int v = 1; v <= 16; v++) begin
            send_a(8'(v), 2'd0);
            #1;
            chk("pt_ready", 64'(ifa.in_ready), 64'h1);
            cyc();
            chk("pt_data", 64'(ifa.out_data[7:0]), 64'(v));
            chk("pt_valid", 64'(ifa.out_valid), 64'b0001);
        end
        ifa.in_valid = 1'b0;
        cyc();
        chk("pt_empty", 64'(ifa.out_valid), 64'h0);

        // Simultaneous drain of lanes 0/2 with load of lane 1
        ifa.out_ready = 4'b0000;
        send_a(8'h50, 2'd0);
        cyc();
        send_a(8'h52, 2'd2);
        cyc();
        chk("sim_pre", 64'(ifa.out_valid), 64'b0101);
        send_a(8'h51, 2'd1);
        ifa.out_ready = 4'b0101;
        cyc();
        chk("sim_post", 64'(ifa.out_valid), 64'b0010);
        chk("sim_data", 64'(ifa.out_data[15:8]), 64'h51);
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 4'hF;
        cyc();
        chk("sim_empty", 64'(ifa.out_valid), 64'h0);

        // Reset mid-operation with lane 2 full and a beat on offer
        ifa.out_ready = 4'b0000;
        send_a(8'hC2, 2'd2);
        cyc();
        chk("mr_full", 64'(ifa.out_valid), 64'b0100);
        send_a(8'h0C, 2'd0);
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(ifa.out_valid), 64'h0);
        chk("mr_data", 64'(ifa.out_data), 64'h0);
        chk("mr_ready", 64'(ifa.in_ready), 64'h0);
        cyc();
        chk("mr_drop", 64'(ifa.drop_count), 64'h0);
        chk("mr_valid2", 64'(ifa.out_valid), 64'h0);
        ifa.in_valid = 1'b0;
        rst = 1'b0;
        cyc();
        chk("mr_after", 64'(ifa.out_valid), 64'h0);

        // Out-of-range drop on the N=3 instance
        ifb.out_ready = 3'b000;
        ifb.in_sel    = 2'd3;
        ifb.in_valid  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            ifb.in_data = 8'h90 + 8'(j);
            #1;
            chk("drop_ready", 64'(ifb.in_ready), 64'h1);
            cyc();
            chk("drop_count_b", 64'(ifb.drop_count), 64'(drop_exp[j]));
            chk("drop_valid", 64'(ifb.out_valid), 64'h0);
        end
        ifb.in_sel  = 2'd2;
        ifb.in_data = 8'h77;
        cyc();
        ifb.in_valid = 1'b0;
        chk("b_lane2_valid", 64'(ifb.out_valid), 64'b100);
        chk("b_lane2_data", 64'(ifb.out_data[23:16]), 64'h77);
        chk("b_drop_hold", 64'(ifb.drop_count), 64'h3);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
